// File: rtl/video_frame_ctrl.sv
// Video frame controller: measures line length, locks onto the frame timing and gates
// de with per-pixel x/y coordinates. Define VFC_LINE_CHECK_EN to drop lock on a bad line.
module video_frame_ctrl #(
   parameter int XW = 11,
   parameter int YW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          de_in,
   input  logic          h_sync_in,
   input  logic          v_sync_in,
   input  logic [7:0]    pixel_in,
   output logic          de_out,
   output logic          h_sync_out,
   output logic          v_sync_out,
   output logic [7:0]    pixel_out,
   output logic [XW-1:0] x_out,
   output logic [YW-1:0] y_out,
   output logic          frame_start,
   output logic          line_start,
   output logic          locked,
   output logic          line_err
);

   localparam logic [1:0] ST_UNLOCKED   = 2'd0;
   localparam logic [1:0] ST_MEASURE    = 2'd1;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
   localparam logic [1:0] ST_LOCKED     = 2'd3;

   localparam logic [XW-1:0] X_MAX  = {XW{1'b1}};
   localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
   localparam logic [XW-1:0] X_ONE  = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [YW-1:0] Y_MAX  = {YW{1'b1}};
   localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
   localparam logic [YW-1:0] Y_ONE  = {{(YW-1){1'b0}}, 1'b1};

   logic          v_q_r;
   logic          de_q_r;
   logic [1:0]    state_r;
   logic [XW-1:0] line_len_r;
   logic          fs_pend_r;

   logic          vs_rise_s;
   logic          de_rise_s;
   logic          de_fall_s;
   logic          de_gate_s;
   logic [XW-1:0] x_nxt_s;
   logic [YW-1:0] y_nxt_s;
   logic [XW-1:0] line_cnt_s;
   logic [1:0]    state_nxt_s;
   logic          err_s;

   assign vs_rise_s  = v_sync_in & ~v_q_r;
   assign de_rise_s  = de_in & ~de_q_r;
   assign de_fall_s  = ~de_in & de_q_r;
   assign de_gate_s  = de_in & (state_r == ST_LOCKED);
   // x_out holds the last assigned x, so the finished line's pixel count is x_out + 1
   assign line_cnt_s = x_out + X_ONE;

   // Coordinate counters; the output registers double as the counters
   always_comb begin
      x_nxt_s = x_out;
      y_nxt_s = y_out;
      if (de_rise_s) begin
         x_nxt_s = X_ZERO;
      end else if (de_in) begin
         x_nxt_s = (x_out == X_MAX) ? X_MAX : (x_out + X_ONE);
      end else begin
         x_nxt_s = x_out;
      end
      if (vs_rise_s) begin
         y_nxt_s = Y_ZERO;
      end else if (de_fall_s) begin
         y_nxt_s = (y_out == Y_MAX) ? Y_MAX : (y_out + Y_ONE);
      end else begin
         y_nxt_s = y_out;
      end
   end

   // Lock state machine and line-length mismatch detection
   always_comb begin
      state_nxt_s = state_r;
      err_s       = 1'b0;
      case (state_r)
         ST_UNLOCKED: begin
            if (vs_rise_s) state_nxt_s = ST_MEASURE;
            else           state_nxt_s = ST_UNLOCKED;
         end
         ST_MEASURE: begin
            if (vs_rise_s)      state_nxt_s = ST_MEASURE;
            else if (de_fall_s) state_nxt_s = ST_WAIT_FRAME;
            else                state_nxt_s = ST_MEASURE;
         end
         ST_WAIT_FRAME: begin
            if (vs_rise_s) state_nxt_s = ST_LOCKED;
            else           state_nxt_s = ST_WAIT_FRAME;
         end
         ST_LOCKED: begin
`ifdef VFC_LINE_CHECK_EN
            // a saturated x counter means the line overran the counter: always a mismatch
            if (de_fall_s && ((x_out == X_MAX) || (line_cnt_s != line_len_r))) begin
               state_nxt_s = ST_UNLOCKED;
               err_s       = 1'b1;
            end else begin
               state_nxt_s = ST_LOCKED;
            end
`else
            state_nxt_s = ST_LOCKED;
`endif
         end
         default: state_nxt_s = ST_UNLOCKED;
      endcase
   end

   // State, edge history, line length and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q_r       <= 1'b0;
         de_q_r      <= 1'b0;
         state_r     <= ST_UNLOCKED;
         line_len_r  <= X_ZERO;
         fs_pend_r   <= 1'b0;
         de_out      <= 1'b0;
         h_sync_out  <= 1'b0;
         v_sync_out  <= 1'b0;
         pixel_out   <= 8'd0;
         x_out       <= X_ZERO;
         y_out       <= Y_ZERO;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         locked      <= 1'b0;
         line_err    <= 1'b0;
      end else begin
         v_q_r       <= v_sync_in;
         de_q_r      <= de_in;
         state_r     <= state_nxt_s;
         if ((state_r == ST_MEASURE) && de_fall_s && !vs_rise_s) begin
            line_len_r <= line_cnt_s;
         end
         if (de_gate_s)      fs_pend_r <= 1'b0;
         else if (vs_rise_s) fs_pend_r <= 1'b1;
         de_out      <= de_gate_s;
         h_sync_out  <= h_sync_in;
         v_sync_out  <= v_sync_in;
         pixel_out   <= pixel_in;
         x_out       <= x_nxt_s;
         y_out       <= y_nxt_s;
         frame_start <= de_gate_s & (fs_pend_r | vs_rise_s);
         line_start  <= de_gate_s & (x_nxt_s == X_ZERO);
         locked      <= (state_nxt_s == ST_LOCKED);
         line_err    <= err_s;
      end
   end

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Scoreboard bench for video_frame_ctrl: gated pixels are predicted as they are driven
// and matched against de_out; pass-through controls are checked every cycle.
module tb_video_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        de_in, h_sync_in, v_sync_in;
   logic [7:0]  pixel_in;
   logic        de_out, h_sync_out, v_sync_out;
   logic [7:0]  pixel_out;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        frame_start, line_start, locked, line_err;

   typedef struct {
      logic [7:0] pix;
      int         x;
      int         y;
      bit         fs;
      bit         ls;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   err_count = 0;
   int   err_cyc = -1;
   int   cyc = 0;
   int   defall_cyc = 0;
   logic exp_rst = 1'b1;
   logic exp_h = 1'b0, exp_v = 1'b0;
   logic [7:0] exp_pix = 8'd0;

   video_frame_ctrl #(.XW(11), .YW(10)) dut (
      .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .pixel_in(pixel_in), .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
      .pixel_out(pixel_out), .x_out(x_out), .y_out(y_out), .frame_start(frame_start),
      .line_start(line_start), .locked(locked), .line_err(line_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      exp_rst <= rst;
      exp_h   <= h_sync_in;
      exp_v   <= v_sync_in;
      exp_pix <= pixel_in;
   end

   // Scoreboard monitor: pass-through controls every cycle, gated pixels popped on de_out
   always @(negedge clk) begin
      exp_t e;
      n_checks++;
      if (exp_rst) begin
         if ({de_out, h_sync_out, v_sync_out, frame_start, line_start, locked, line_err} !== 7'd0 ||
             pixel_out !== 8'd0 || x_out !== 11'd0 || y_out !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got de=%b x=%0d y=%0d pix=%0h locked=%b, required all 0",
                     de_out, x_out, y_out, pixel_out, locked);
         end
      end else begin
         if (h_sync_out !== exp_h || v_sync_out !== exp_v || pixel_out !== exp_pix) begin
            n_fail++;
            $display("FAIL passthrough: got h=%b v=%b pix=%0h, required h=%b v=%b pix=%0h",
                     h_sync_out, v_sync_out, pixel_out, exp_h, exp_v, exp_pix);
         end
         if (de_out) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_de: got de_out=1 x=%0d y=%0d, required de_out=0", x_out, y_out);
            end else begin
               e = sb_q.pop_front();
               if (pixel_out !== e.pix || x_out !== e.x[10:0] || y_out !== e.y[9:0] ||
                   frame_start !== e.fs || line_start !== e.ls) begin
                  n_fail++;
                  $display("FAIL gated_pixel: got pix=%0h x=%0d y=%0d fs=%b ls=%b, required pix=%0h x=%0d y=%0d fs=%b ls=%b",
                           pixel_out, x_out, y_out, frame_start, line_start, e.pix, e.x, e.y, e.fs, e.ls);
               end
            end
         end else if (frame_start || line_start) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_without_de: got fs=%b ls=%b, required 0", frame_start, line_start);
         end
         if (line_err) begin
            err_count++;
            err_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      v_sync_in = 1'b1;
      tick(); tick();
      v_sync_in = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic drive_line(input int len, input bit gated, input int y, input bit fs, input bit vs_end);
      exp_t e;
      h_sync_in = 1'b1;
      tick(); tick();
      h_sync_in = 1'b0;
      tick(); tick();
      for (int i = 0; i < len; i++) begin
         de_in    = 1'b1;
         pixel_in = 8'($urandom);
         if (gated) begin
            e.pix = pixel_in;
            e.x   = (i > 2047) ? 2047 : i;
            e.y   = y;
            e.fs  = fs && (i == 0);
            e.ls  = (i == 0);
            sb_q.push_back(e);
         end
         tick();
      end
      de_in      = 1'b0;
      defall_cyc = cyc;
      if (vs_end) v_sync_in = 1'b1;
      tick(); tick();
      v_sync_in = 1'b0;
      tick(); tick();
   endtask

   task automatic drive_frame(input int len, input bit gated);
      vs_pulse();
      for (int l = 0; l < 4; l++) drive_line(len, gated, l, gated && (l == 0), 1'b0);
   endtask

   task automatic check_locked(input string name, input logic want);
      n_checks++;
      if (locked !== want) begin
         n_fail++;
         $display("FAIL %s: got locked=%b, required %b", name, locked, want);
      end
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: got %0d pixels still expected, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 8'd0;
      tick(); tick(); tick();
      n_checks++;
      if (de_out !== 1'b0 || x_out !== 11'd0 || y_out !== 10'd0 || line_err !== 1'b0) begin
         n_fail++;
         $display("FAIL test_reset: got de=%b x=%0d y=%0d err=%b, required 0", de_out, x_out, y_out, line_err);
      end
      check_locked("test_reset_locked", 1'b0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lock();
      drive_frame(640, 1'b0);
      check_locked("lock_after_measure", 1'b0);
      check_drained("lock_measure_frame");
      drive_frame(640, 1'b1);
      check_locked("lock_frame2", 1'b1);
      drive_frame(640, 1'b1);
      check_locked("lock_frame3", 1'b1);
      check_drained("lock_frames");
      n_checks++;
      if (err_count != 0) begin
         n_fail++;
         $display("FAIL lock_no_err: got %0d line_err pulses, required 0", err_count);
      end
   endtask

   task automatic test_line_err();
      int e0, d;
      e0 = err_count;
      vs_pulse();
      drive_line(640, 1'b1, 0, 1'b1, 1'b0);
      drive_line(639, 1'b1, 1, 1'b0, 1'b0);
      d = defall_cyc;
`ifdef VFC_LINE_CHECK_EN
      drive_line(640, 1'b0, 2, 1'b0, 1'b0);
      drive_line(640, 1'b0, 3, 1'b0, 1'b0);
      n_checks++;
      if (err_count != e0 + 1 || err_cyc != d + 1) begin
         n_fail++;
         $display("FAIL line_err_pulse: got %0d pulses at cycle %0d, required 1 at cycle %0d",
                  err_count - e0, err_cyc, d + 1);
      end
      check_locked("line_err_unlocked", 1'b0);
      drive_frame(640, 1'b0);
      check_locked("line_err_measure", 1'b0);
      drive_frame(640, 1'b1);
      check_locked("line_err_relock", 1'b1);
`else
      drive_line(640, 1'b1, 2, 1'b0, 1'b0);
      drive_line(640, 1'b1, 3, 1'b0, 1'b0);
      n_checks++;
      if (err_count != e0) begin
         n_fail++;
         $display("FAIL line_err_disabled: got %0d pulses (last at %0d after defall %0d), required 0",
                  err_count - e0, err_cyc, d);
      end
      check_locked("line_err_stay_locked", 1'b1);
`endif
      check_drained("line_err");
   endtask

   task automatic test_vs_defall();
      int e0;
      e0 = err_count;
      vs_pulse();
      drive_line(640, 1'b1, 0, 1'b1, 1'b0);
      drive_line(640, 1'b1, 1, 1'b0, 1'b1);
      for (int l = 0; l < 4; l++) drive_line(640, 1'b1, l, l == 0, 1'b0);
      check_locked("vs_defall_locked", 1'b1);
      check_drained("vs_defall");
      n_checks++;
      if (err_count != e0) begin
         n_fail++;
         $display("FAIL vs_defall_err: got %0d pulses, required 0", err_count - e0);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      vs_pulse();
      h_sync_in = 1'b1;
      tick(); tick();
      h_sync_in = 1'b0;
      tick(); tick();
      for (int i = 0; i < 100; i++) begin
         de_in = 1'b1;
         pixel_in = 8'($urandom);
         e.pix = pixel_in; e.x = i; e.y = 0; e.fs = (i == 0); e.ls = (i == 0);
         sb_q.push_back(e);
         tick();
      end
      pixel_in = 8'($urandom);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (de_out !== 1'b0 || pixel_out !== 8'd0 || x_out !== 11'd0 || y_out !== 10'd0 ||
          frame_start !== 1'b0 || line_start !== 1'b0 || line_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got de=%b pix=%0h x=%0d y=%0d fs=%b ls=%b, required all 0",
                  de_out, pixel_out, x_out, y_out, frame_start, line_start);
      end
      check_locked("reset_mid_unlocked", 1'b0);
      for (int i = 101; i < 640; i++) begin
         pixel_in = 8'($urandom);
         tick();
      end
      de_in = 1'b0;
      tick(); tick();
      for (int l = 1; l < 4; l++) drive_line(640, 1'b0, l, 1'b0, 1'b0);
      check_drained("reset_mid_pre");
      drive_frame(640, 1'b0);
      check_locked("reset_mid_measure", 1'b0);
      drive_frame(640, 1'b1);
      check_locked("reset_mid_relock", 1'b1);
      check_drained("reset_mid");
   endtask

   task automatic test_saturate();
      int e0, d;
      e0 = err_count;
      vs_pulse();
      drive_line(2100, 1'b1, 0, 1'b1, 1'b0);
      d = defall_cyc;
`ifdef VFC_LINE_CHECK_EN
      for (int l = 1; l < 4; l++) drive_line(640, 1'b0, l, 1'b0, 1'b0);
      n_checks++;
      if (err_count != e0 + 1 || err_cyc != d + 1) begin
         n_fail++;
         $display("FAIL saturate_err: got %0d pulses at cycle %0d, required 1 at cycle %0d",
                  err_count - e0, err_cyc, d + 1);
      end
      check_locked("saturate_unlocked", 1'b0);
`else
      for (int l = 1; l < 4; l++) drive_line(640, 1'b1, l, 1'b0, 1'b0);
      n_checks++;
      if (err_count != e0) begin
         n_fail++;
         $display("FAIL saturate_no_err: got %0d pulses (defall %0d), required 0", err_count - e0, d);
      end
      check_locked("saturate_locked", 1'b1);
`endif
      check_drained("saturate");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lock();
      test_line_err();
      test_vs_defall();
      test_reset_mid();
      test_saturate();
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/video_frame_ctrl.md
VIDEO_FRAME_CTRL -- requirements
Module: video_frame_ctrl

Interface
REQ-001 SHALL have parameter XW, default 11, x-coordinate and line-length counter width.
REQ-002 SHALL have parameter YW, default 10, y-coordinate counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports de_in, h_sync_in, v_sync_in  input  1 each  active-high stream controls from the luma converter.
REQ-006 SHALL have port pixel_in  input  8  luma sample.
REQ-007 SHALL have ports de_out, h_sync_out, v_sync_out  output  1 each  registered stream controls; de_out is gated.
REQ-008 SHALL have port pixel_out  output  8  registered luma.
REQ-009 SHALL have ports x_out  output  XW  and y_out  output  YW  coordinates aligned with pixel_out.
REQ-010 SHALL have ports frame_start, line_start  output  1 each  one-cycle pulses on the first gated pixel of a frame or line.
REQ-011 SHALL have ports locked  output  1  (state==LOCKED) and line_err  output  1  one-cycle error pulse.

Function
REQ-012 SHALL register every output; latency from input to output is exactly 1 cycle.
REQ-013 SHALL detect edges against 1-cycle-delayed copies: vs_rise = v_sync_in & ~v_q; de_rise = de_in & ~de_q; de_fall = ~de_in & de_q.
REQ-014 SHALL pass h_sync, v_sync and pixel through ungated in every state.
REQ-015 SHALL implement states UNLOCKED, MEASURE, WAIT_FRAME, LOCKED.
REQ-016 UNLOCKED -> MEASURE on vs_rise.
REQ-017 MEASURE: count de_in cycles of the first line; on de_fall, store the count as line_len and go to WAIT_FRAME.
REQ-018 WAIT_FRAME -> LOCKED on the next vs_rise; a vs_rise in MEASURE before any de_fall restarts MEASURE.
REQ-019 SHALL compute de_out(t+1) = de_in(t) AND state(t)==LOCKED.
REQ-020 x counter: 0 on the first de cycle of a line, +1 per de cycle, saturates at 2^XW-1.
REQ-021 y counter: 0 on vs_rise, +1 on each de_fall, saturates at 2^YW-1.
REQ-022 vs_rise coincident with de_fall: vs_rise wins; y counter goes to 0.
REQ-023 frame_start SHALL pulse with the first gated de_out after LOCKED entry or after vs_rise; line_start SHALL pulse with every gated de_out whose x_out==0.
REQ-024 LOCKED: on de_fall with pixel count != line_len, line_err pulses 1 cycle and state goes to UNLOCKED; the offending line has already passed downstream.
REQ-025 A saturated x counter in LOCKED SHALL be treated as a mismatch at de_fall.

Reset
REQ-026 On rst: state UNLOCKED; all outputs, counters, line_len and edge registers 0.
REQ-027 rst asserted mid-line SHALL force de_out=0 on the next cycle; relock requires a fresh vs_rise and measurement.

Configuration
REQ-028 Macro VFC_LINE_CHECK_EN defined: REQ-024/025 active.
REQ-029 Macro VFC_LINE_CHECK_EN undefined: LOCKED is left only by rst; line_err tied to 0; line_len still stored.

Verification
REQ-030 Frames of 640 px x 4 lines, 1 px/clk, started by vs_rise: frame 1 gated (de_out=0); from frame 2, de_out follows de_in +1 cycle, x_out 0..639, y_out 0..3, locked=1.
REQ-031 Locked at 640, inject one 639-px line: line_err pulses once at that line's de_fall+1; de_out=0 from the next line; relock after 1 measure frame + vs_rise.
REQ-032 Same stimulus with VFC_LINE_CHECK_EN undefined: line_err stays 0, locked stays 1, all lines pass.
REQ-033 vs_rise in the same cycle as de_fall: y_out of the next gated pixel = 0; frame_start pulses.
REQ-034 Assert rst for 1 cycle at pixel 100 of a locked line: next cycle all outputs 0, state UNLOCKED; no de_out until full relock.
REQ-035 Line of 2100 px with XW=11: x_out holds 2047 from pixel 2047 onward; with VFC_LINE_CHECK_EN defined, mismatch -> line_err.
